// File: rtl/tl_instruction_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM states,
// the default halt encoding and the NOP word injected on redirects.
package tl_instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

endpackage

// File: rtl/tl_instruction_fetch_if.sv
// Control/loader inputs and IF/ID outputs of the fetch stage, bundled so the
// pipeline top and the bench share one definition.
interface tl_instruction_fetch_if #(
  parameter int len     = 32,
  parameter int NB_ADDR = 10
);
  logic               i_start;
  logic               i_stall;
  logic               i_pc_src;
  logic [len-1:0]     i_branch_target;
  logic               i_jump;
  logic [len-1:0]     i_jump_target;
  logic               i_load_we;
  logic [NB_ADDR-1:0] i_load_addr;
  logic [len-1:0]     i_load_data;
  logic [len-1:0]     o_instruccion;
  logic [len-1:0]     o_pc_plus4;
  logic               o_valid;
  logic               o_halt;

  modport master (
    output i_start, i_stall, i_pc_src, i_branch_target, i_jump, i_jump_target,
           i_load_we, i_load_addr, i_load_data,
    input  o_instruccion, o_pc_plus4, o_valid, o_halt
  );

  modport slave (
    input  i_start, i_stall, i_pc_src, i_branch_target, i_jump, i_jump_target,
           i_load_we, i_load_addr, i_load_data,
    output o_instruccion, o_pc_plus4, o_valid, o_halt
  );
endinterface

// File: rtl/tl_instruction_fetch_memoria_instrucciones.sv
// Instruction memory: one write port for the loader and a registered read port
// whose output register is the IF/ID instruction register (cleared on flush).
module memoria_instrucciones
  import tl_instruction_fetch_pkg::*;
#(
  parameter int len     = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [len-1:0]     wdata_i,
  input  logic               re_i,
  input  logic               flush_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [len-1:0]     rd_word_o,
  output logic [len-1:0]     data_o
);

  logic [len-1:0] mem_q [2**NB_ADDR];
  logic [len-1:0] data_q;

  // Contents survive reset so a program can be rerun after a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Word about to be captured; lets the top detect a halt on the fetch edge.
  assign rd_word_o = mem_q[raddr_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= len'(NOP_WORD);
    end else if (flush_i) begin
      data_q <= len'(NOP_WORD);
    end else if (re_i) begin
      data_q <= mem_q[raddr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/tl_instruction_fetch.sv
// MIPS instruction-fetch stage: PC, next-PC priority mux and LOAD/RUN/HALT FSM.
// Define FETCH_DEBUG_EN to expose o_pc and a RUN-cycle counter.
module tl_instruction_fetch
  import tl_instruction_fetch_pkg::*;
#(
  parameter int             len       = 32,
  parameter int             NB_ADDR   = 10,
  parameter logic [len-1:0] HALT_WORD = len'(HALT_WORD_DEFAULT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  tl_instruction_fetch_if.slave   fetch_if
`ifdef FETCH_DEBUG_EN
  ,
  output logic [len-1:0]          o_pc,
  output logic [31:0]             o_cycle_count
`endif
);

  fetch_state_e   state_q, state_d;
  logic [len-1:0] pc_q, pc_d;
  logic [len-1:0] pc_plus4_q, pc_plus4_d;
  logic           valid_q, valid_d;
  logic [len-1:0] pc_inc;
  logic [len-1:0] rd_word;
  logic [len-1:0] instr;
  logic           mem_we;
  logic           rd_en;
  logic           flush;

  memoria_instrucciones #(
    .len     (len),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .clk_i     (i_clk),
    .rst_ni    (i_rst),
    .we_i      (mem_we),
    .waddr_i   (fetch_if.i_load_addr),
    .wdata_i   (fetch_if.i_load_data),
    .re_i      (rd_en),
    .flush_i   (flush),
    .raddr_i   (pc_q[NB_ADDR+1:2]),
    .rd_word_o (rd_word),
    .data_o    (instr)
  );

  assign pc_inc = pc_q + len'(4);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_LOAD;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        mem_we = fetch_if.i_load_we;
        if (fetch_if.i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Redirects beat stalls: the younger fetch is squashed anyway.
        if (fetch_if.i_jump) begin
          pc_d    = fetch_if.i_jump_target & ~len'(3);
          flush   = 1'b1;
          valid_d = 1'b0;
        end else if (fetch_if.i_pc_src) begin
          pc_d    = fetch_if.i_branch_target & ~len'(3);
          flush   = 1'b1;
          valid_d = 1'b0;
        end else if (!fetch_if.i_stall) begin
          rd_en      = 1'b1;
          pc_plus4_d = pc_inc;
          valid_d    = 1'b1;
          if (rd_word == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign fetch_if.o_instruccion = instr;
  assign fetch_if.o_pc_plus4    = pc_plus4_q;
  assign fetch_if.o_valid       = valid_q;
  assign fetch_if.o_halt        = (state_q == ST_HALT);

`ifdef FETCH_DEBUG_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cycle_count_q <= '0;
    end else if (state_q == ST_RUN) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign o_pc          = pc_q;
  assign o_cycle_count = cycle_count_q;
`endif

endmodule
